// File: rtl/prog_tick_counter.sv
// Programmable terminal-count tick generator: periodic or one-shot, with sticky done.
// Optional macro TICKCNT_PRESCALE_EN adds a tick_in strobe gating every advance cycle.
module prog_tick_counter #(
    parameter int WIDTH         = 7,
    parameter int DEFAULT_LIMIT = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             mode,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] limit_in,
    input  logic             done_ack,
`ifdef TICKCNT_PRESCALE_EN
    input  logic             tick_in,
`endif
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] limit
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t state;
    logic   one_shot;
    logic   advance;
    logic   terminal;

`ifdef TICKCNT_PRESCALE_EN
    assign advance = (state == RUN) && en && tick_in;
`else
    assign advance = (state == RUN) && en;
`endif
    // >= (not ==) so a limit lowered below the running count still terminates
    assign terminal = advance && (count >= limit);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            tick     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            limit    <= WIDTH'(DEFAULT_LIMIT);
            one_shot <= 1'b0;
        end else begin
            // load is independent of the state machine; compare above sees the old limit
            if (load)
                limit <= limit_in;

            if (clr) begin
                state <= IDLE;
                count <= '0;
                tick  <= 1'b0;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else if (start) begin
                state    <= RUN;
                count    <= '0;
                tick     <= 1'b0;
                busy     <= 1'b1;
                one_shot <= mode;
                if (done_ack)
                    done <= 1'b0;
            end else if (terminal) begin
                count <= '0;
                tick  <= 1'b1;
                done  <= 1'b1;
                if (one_shot) begin
                    state <= HALT;
                    busy  <= 1'b0;
                end
            end else begin
                if (advance)
                    count <= count + 1'b1;
                tick <= 1'b0;
                if (done_ack)
                    done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prog_tick_counter.sv
// Scoreboard bench for prog_tick_counter: directed scenarios then random traffic vs a reference model.
module tb_prog_tick_counter;

    localparam int W  = 7;
    localparam int DL = 100;
`ifdef TICKCNT_PRESCALE_EN
    localparam bit PS = 1'b1;
`else
    localparam bit PS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1, en = 1'b0, start = 1'b0, mode = 1'b0;
    logic         clr = 1'b0, load = 1'b0, done_ack = 1'b0, tick_in = 1'b0;
    logic [W-1:0] limit_in = '0;
    logic         tick, busy, done;
    logic [W-1:0] count, limit;

    prog_tick_counter #(.WIDTH(W), .DEFAULT_LIMIT(DL)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .mode(mode), .clr(clr),
        .load(load), .limit_in(limit_in), .done_ack(done_ack),
`ifdef TICKCNT_PRESCALE_EN
        .tick_in(tick_in),
`endif
        .tick(tick), .busy(busy), .done(done), .count(count), .limit(limit)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit tick, busy, done;
        int count, limit;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: running flag, one-shot flag, integer count and limit.
    bit m_run = 0, m_one = 0, m_tick = 0, m_done = 0;
    int m_cnt = 0, m_lim = DL;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit e, input bit s, input bit md, input bit c,
                         input bit l, input int li, input bit ack, input bit ti);
        int   old_lim;
        exp_t x;
        @(negedge clk);
        rst = r; en = e; start = s; mode = md; clr = c; load = l;
        limit_in = li[W-1:0]; done_ack = ack; tick_in = ti;
        old_lim = m_lim;
        if (r) begin
            m_run = 0; m_one = 0; m_tick = 0; m_done = 0; m_cnt = 0; m_lim = DL;
        end else begin
            if (l) m_lim = li;
            if (c) begin
                m_run = 0; m_cnt = 0; m_tick = 0; m_done = 0;
            end else if (s) begin
                m_run = 1; m_one = md; m_cnt = 0; m_tick = 0;
                if (ack) m_done = 0;
            end else if (m_run && e && (!PS || ti) && m_cnt >= old_lim) begin
                m_cnt = 0; m_tick = 1; m_done = 1;
                if (m_one) m_run = 0;
            end else begin
                if (m_run && e && (!PS || ti)) m_cnt = m_cnt + 1;
                m_tick = 0;
                if (ack) m_done = 0;
            end
        end
        x.tick = m_tick; x.busy = m_run; x.done = m_done; x.count = m_cnt; x.limit = m_lim;
        q.push_back(x);
    endtask

    // Monitor: outputs are valid every cycle, compared just after each rising edge
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("tick",  int'(tick),  int'(x.tick));
                chk("busy",  int'(busy),  int'(x.busy));
                chk("done",  int'(done),  int'(x.done));
                chk("count", int'(count), x.count);
                chk("limit", int'(limit), x.limit);
            end
        end
    end

    initial begin
        // reset
        repeat (2) drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
        // periodic with default limit: two full 101-cycle periods
        drive(0, 1, 1, 0, 0, 0, 0, 0, 1);
        repeat (210) drive(0, 1, 0, 0, 0, 0, 0, 0, 1);
        // one-shot, limit 3
        drive(0, 1, 0, 0, 0, 1, 3, 0, 1);
        drive(0, 1, 1, 1, 0, 0, 0, 0, 1);
        repeat (10) drive(0, 1, 0, 0, 0, 0, 0, 0, 1);
        // periodic limit 10, lower to 4 when count reaches 7
        drive(0, 0, 0, 0, 0, 1, 10, 0, 1);
        drive(0, 1, 1, 0, 0, 0, 0, 0, 1);
        repeat (7) drive(0, 1, 0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1, 4, 0, 1);
        repeat (14) drive(0, 1, 0, 0, 0, 0, 0, 0, 1);
        // done_ack held through terminal cycles, then clr with start
        repeat (12) drive(0, 1, 0, 0, 0, 0, 0, 1, 1);
        drive(0, 1, 1, 0, 1, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 1);
        // en toggling with limit 2, then reset mid-run
        drive(0, 0, 0, 0, 0, 1, 2, 0, 1);
        drive(0, 0, 1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) drive(0, (i % 2) == 0, 0, 0, 0, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 1);
        drive(1, 1, 1, 1, 1, 1, 9, 1, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        // external strobe every 4th clock, limit 4
        drive(0, 0, 0, 0, 0, 1, 4, 0, 1);
        drive(0, 1, 1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 45; i++) drive(0, 1, 0, 0, 0, 0, 0, 0, (i % 4) == 3);
        // random traffic with small limits
        drive(0, 0, 0, 0, 0, 1, 3, 0, 1);
        for (int i = 0; i < 2500; i++)
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 24) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 39) == 0, $urandom_range(0, 14) == 0,
                  int'($urandom_range(0, 12)), $urandom_range(0, 4) == 0,
                  $urandom_range(0, 2) != 0);
        repeat (3) @(posedge clk);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
